// File: rtl/panel_mem_wr_arbiter.sv
// Write-port scheduler for the LED panel frame memory: round-robin between two
// streaming requesters with bounded bursts, plus a full-frame clear engine.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; pick clear, then a requester, one dead cycle
// S_GNT0  | requester 0 owns the write port
// S_GNT1  | requester 1 owns the write port
// S_CLEAR | sweeping addresses 0..DEPTH-1 with the captured fill value
module panel_mem_wr_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 24,
    parameter int DEPTH     = 2048,
    parameter int MAX_BURST = 64,
    parameter int TIMEOUT   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr_req,
    input  logic [DATA_W-1:0] i_clr_data,
    output logic              o_clr_busy,
    input  logic              i_r0_valid,
    output logic              o_r0_ready,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_data,
    input  logic              i_r0_last,
    input  logic              i_r1_valid,
    output logic              o_r1_ready,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_data,
    input  logic              i_r1_last,
    output logic [1:0]        o_grant,
    output logic              o_we_a,
    output logic [ADDR_W-1:0] o_mem_w_address,
    output logic [DATA_W-1:0] o_mem_w_data
);

    localparam int                BEAT_W   = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
    localparam logic [3:0]        IDLE_MAX = 4'(TIMEOUT);
    localparam logic [ADDR_W-1:0] CLR_END  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_GNT0, S_GNT1, S_CLEAR} state_t;

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_grant;
    logic                r_rdy0;
    logic                r_rdy1;
    logic                r_clr_busy;
    logic                r_clr_pend;
    logic                r_clr_done;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [DATA_W-1:0]   r_clr_val;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [3:0]          r_idle_cnt;
    logic                r_last_srv;

    logic                w_own1;
    logic                w_valid;
    logic                w_last;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_data;
    logic                w_hs;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [3:0]          w_idle_nxt;
    logic                w_release;
    logic                w_pick0;

    assign w_own1     = (r_state == S_GNT1);
    assign w_valid    = w_own1 ? i_r1_valid : i_r0_valid;
    assign w_last     = w_own1 ? i_r1_last  : i_r0_last;
    assign w_addr     = w_own1 ? i_r1_addr  : i_r0_addr;
    assign w_data     = w_own1 ? i_r1_data  : i_r0_data;
    assign w_hs       = (r_rdy0 & i_r0_valid) | (r_rdy1 & i_r1_valid);
    assign w_beat_nxt = r_beat_cnt + 1'b1;
    assign w_idle_nxt = r_idle_cnt + 1'b1;
    // Ready is held high for the whole grant, so no handshake means valid is low.
    assign w_release  = w_hs ? (w_last || (w_beat_nxt == BEAT_MAX))
                             : (w_idle_nxt == IDLE_MAX);
    assign w_pick0    = i_r0_valid & (~i_r1_valid | r_last_srv);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_grant    <= 2'b00;
            r_rdy0     <= 1'b0;
            r_rdy1     <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_pend <= 1'b0;
            r_clr_done <= 1'b0;
            r_clr_addr <= '0;
            r_clr_val  <= '0;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_last_srv <= 1'b1;
        end else begin
            r_we <= 1'b0;
            if (i_clr_req && (r_state != S_CLEAR)) begin
                r_clr_pend <= 1'b1;
                r_clr_busy <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_clr_pend) begin
                        r_state    <= S_CLEAR;
                        r_clr_val  <= i_clr_data;
                        r_clr_addr <= '0;
                        r_clr_done <= 1'b0;
                    end else if (w_pick0) begin
                        r_state    <= S_GNT0;
                        r_rdy0     <= 1'b1;
                        r_grant    <= 2'b01;
                        r_beat_cnt <= '0;
                        r_idle_cnt <= '0;
                    end else if (i_r1_valid) begin
                        r_state    <= S_GNT1;
                        r_rdy1     <= 1'b1;
                        r_grant    <= 2'b10;
                        r_beat_cnt <= '0;
                        r_idle_cnt <= '0;
                    end
                end
                S_GNT0, S_GNT1: begin
                    if (w_hs) begin
                        r_we       <= 1'b1;
                        r_addr     <= w_addr;
                        r_data     <= w_data;
                        r_beat_cnt <= w_beat_nxt;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= w_idle_nxt;
                    end
                    if (w_release) begin
                        r_state    <= S_IDLE;
                        r_rdy0     <= 1'b0;
                        r_rdy1     <= 1'b0;
                        r_grant    <= 2'b00;
                        r_last_srv <= w_own1;
                    end
                end
                S_CLEAR: begin
                    // The address counter wraps when DEPTH fills the space, so a
                    // separate flag marks the final write.
                    if (!r_clr_done) begin
                        r_we       <= 1'b1;
                        r_addr     <= r_clr_addr;
                        r_data     <= r_clr_val;
                        r_clr_addr <= r_clr_addr + 1'b1;
                        if (r_clr_addr == CLR_END) r_clr_done <= 1'b1;
                    end else begin
                        r_state    <= S_IDLE;
                        r_clr_pend <= 1'b0;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_we_a          = r_we;
    assign o_mem_w_address = r_addr;
    assign o_mem_w_data    = r_data;
    assign o_grant         = r_grant;
    assign o_r0_ready      = r_rdy0;
    assign o_r1_ready      = r_rdy1;
    assign o_clr_busy      = r_clr_busy;

endmodule

// File: tb/tb_panel_mem_wr_arbiter.sv
// Bench for panel_mem_wr_arbiter: directed timing scenarios plus randomized bursts
// checked against a transaction-level round-robin model of the write stream.
module tb_panel_mem_wr_arbiter;
    localparam int AW   = 11;
    localparam int DW   = 24;
    localparam int MAXB = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_req = 1'b0;
    logic [DW-1:0] clr_data = '0;
    logic          clr_busy;
    logic          r0_valid = 1'b0, r1_valid = 1'b0;
    logic          r0_ready, r1_ready;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_data = '0, r1_data = '0;
    logic          r0_last = 1'b0, r1_last = 1'b0;
    logic [1:0]    grant;
    logic          we_a;
    logic [AW-1:0] mem_w_address;
    logic [DW-1:0] mem_w_data;

    panel_mem_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2048), .MAX_BURST(MAXB), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .i_clr_data(clr_data), .o_clr_busy(clr_busy),
        .i_r0_valid(r0_valid), .o_r0_ready(r0_ready), .i_r0_addr(r0_addr), .i_r0_data(r0_data), .i_r0_last(r0_last),
        .i_r1_valid(r1_valid), .o_r1_ready(r1_ready), .i_r1_addr(r1_addr), .i_r1_data(r1_data), .i_r1_last(r1_last),
        .o_grant(grant), .o_we_a(we_a), .o_mem_w_address(mem_w_address), .o_mem_w_data(mem_w_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d; logic l;} beat_t;
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;

    beat_t      q0[$], q1[$];
    wr_t        obs[$], exp_wr[$];
    logic [1:0] obs_g[$], exp_g[$];
    bit         en0, en1, model_ls;
    logic [1:0] prev_grant;
    int         rr_viol;
    int         total = 0, bad = 0;

    task automatic drive_inputs();
        beat_t b0, b1;
        b0 = '0; b1 = '0;
        if (q0.size() > 0) b0 = q0[0];
        if (q1.size() > 0) b1 = q1[0];
        r0_valid = en0 && (q0.size() > 0); r0_addr = b0.a; r0_data = b0.d; r0_last = b0.l;
        r1_valid = en1 && (q1.size() > 0); r1_addr = b1.a; r1_data = b1.d; r1_last = b1.l;
    endtask

    // Advance one cycle from a negedge, log outputs, retire accepted beats.
    task automatic step();
        bit h0, h1;
        wr_t w;
        h0 = r0_valid & r0_ready;
        h1 = r1_valid & r1_ready;
        @(posedge clk);
        @(negedge clk);
        if (we_a) begin w.a = mem_w_address; w.d = mem_w_data; obs.push_back(w); end
        if (grant != 2'b00 && prev_grant != 2'b00 && grant != prev_grant) rr_viol++;
        if (grant != 2'b00 && grant != prev_grant) obs_g.push_back(grant);
        prev_grant = grant;
        if (h0) void'(q0.pop_front());
        if (h1) void'(q1.pop_front());
        drive_inputs();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; clr_req = 1'b0; clr_data = '0;
        en0 = 0; en1 = 0; q0.delete(); q1.delete();
        drive_inputs();
        obs.delete(); obs_g.delete(); rr_viol = 0; prev_grant = 2'b00; model_ls = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic gen_bursts(input bit which, input int nb, input int lmin, input int lmax);
        for (int k = 0; k < nb; k++) begin
            int len;
            len = $urandom_range(lmax, lmin);
            for (int j = 0; j < len; j++) begin
                beat_t b;
                b.a = AW'($urandom); b.d = DW'($urandom) | 24'h1; b.l = (j == len - 1);
                if (which) q1.push_back(b); else q0.push_back(b);
            end
        end
    endtask

    // Transaction-level reference: whole bursts served alternately, each ending at
    // last, at MAX_BURST beats, or when its requester runs out of beats.
    task automatic predict();
        beat_t p0[$], p1[$], b;
        bit own;
        int n;
        wr_t w;
        p0 = q0; p1 = q1; exp_wr.delete(); exp_g.delete();
        while (p0.size() > 0 || p1.size() > 0) begin
            own = !(p0.size() > 0 && (p1.size() == 0 || model_ls));
            exp_g.push_back(own ? 2'b10 : 2'b01);
            n = 0;
            do begin
                if (own) b = p1.pop_front(); else b = p0.pop_front();
                w.a = b.a; w.d = b.d; exp_wr.push_back(w);
                n++;
            end while (!b.l && n < MAXB && (own ? p1.size() : p0.size()) > 0);
            model_ls = own;
        end
    endtask

    task automatic run_traffic(input int budget, output bit ok);
        ok = 0;
        drive_inputs();
        for (int i = 0; i < budget; i++) begin
            step();
            if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00 && !we_a) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (we_a !== 1'b0) begin bad++; $display("FAIL rst_we: got=%b want=0", we_a); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL rst_grant: got=%b want=00", grant); end
        total++; if ({r0_ready, r1_ready} !== 2'b00) begin bad++; $display("FAIL rst_ready: got=%b want=00", {r0_ready, r1_ready}); end
        total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b want=0", clr_busy); end
        total++; if ({mem_w_address, mem_w_data} !== '0) begin bad++; $display("FAIL rst_addr_data: got=%h/%h want=0/0", mem_w_address, mem_w_data); end
        apply_reset();
        repeat (3) step();
        total++; if ({we_a, grant, clr_busy} !== 4'b0) begin bad++; $display("FAIL idle_after_rst: got=%b want=0000", {we_a, grant, clr_busy}); end
    endtask

    task automatic test_single_beat();
        beat_t b;
        apply_reset();
        b.a = 11'h005; b.d = 24'hABCDEF; b.l = 1'b1;
        q0.push_back(b); en0 = 1; drive_inputs();
        total++; if ({grant, r0_ready} !== 3'b000) begin bad++; $display("FAIL sb_c0: got grant/rdy=%b want=000", {grant, r0_ready}); end
        step();
        total++; if ({grant, r0_ready, we_a} !== 4'b0110) begin bad++; $display("FAIL sb_c1: got grant/rdy/we=%b want=0110", {grant, r0_ready, we_a}); end
        step();
        total++; if ({we_a, mem_w_address, mem_w_data} !== {1'b1, 11'h005, 24'hABCDEF}) begin
            bad++; $display("FAIL sb_write: got we=%b addr=%h data=%h want we=1 addr=005 data=abcdef", we_a, mem_w_address, mem_w_data); end
        total++; if ({grant, r0_ready} !== 3'b000) begin bad++; $display("FAIL sb_release: got grant/rdy=%b want=000", {grant, r0_ready}); end
        step();
        total++; if (we_a !== 1'b0) begin bad++; $display("FAIL sb_single_pulse: got we=%b want=0", we_a); end
        model_ls = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        apply_reset();
        gen_bursts(0, 3, 3, 3); gen_bursts(1, 3, 3, 3);
        en0 = 1; en1 = 1;
        predict();
        run_traffic(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_drain: got=stuck want=drained"); end
        total++; if (obs.size() != exp_wr.size()) begin bad++; $display("FAIL rr_count: got=%0d want=%0d", obs.size(), exp_wr.size()); end
        for (int i = 0; i < obs.size() && i < exp_wr.size(); i++) begin
            total++; if (obs[i] !== exp_wr[i]) begin bad++; $display("FAIL rr_wr[%0d]: got=%h want=%h", i, obs[i], exp_wr[i]); end
        end
        total++; if (obs_g != exp_g) begin bad++; $display("FAIL rr_grants: got=%p want=%p", obs_g, exp_g); end
        total++; if (rr_viol != 0) begin bad++; $display("FAIL rr_dead_cycle: got=%0d direct switches want=0", rr_viol); end
    endtask

    task automatic test_max_burst();
        bit ok;
        apply_reset();
        for (int j = 0; j < 70; j++) begin
            beat_t b;
            b.a = AW'(j); b.d = DW'($urandom) | 24'h1; b.l = (j == 69);
            q0.push_back(b);
        end
        gen_bursts(1, 1, 2, 2);
        en0 = 1; en1 = 1;
        predict();
        run_traffic(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL mb_drain: got=stuck want=drained"); end
        total++; if (obs.size() != exp_wr.size()) begin bad++; $display("FAIL mb_count: got=%0d want=%0d", obs.size(), exp_wr.size()); end
        for (int i = 0; i < obs.size() && i < exp_wr.size(); i++) begin
            total++; if (obs[i] !== exp_wr[i]) begin bad++; $display("FAIL mb_wr[%0d]: got=%h want=%h", i, obs[i], exp_wr[i]); end
        end
        total++; if (obs_g != exp_g) begin bad++; $display("FAIL mb_grants: got=%p want=%p", obs_g, exp_g); end
    endtask

    task automatic test_timeout();
        beat_t a, b;
        int extra_we;
        apply_reset();
        a.a = AW'($urandom); a.d = DW'($urandom); a.l = 1'b0;
        b.a = AW'($urandom); b.d = DW'($urandom); b.l = 1'b0;
        q1.push_back(a); q1.push_back(b); en1 = 1; drive_inputs();
        step();
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL to_grant: got=%b want=10", grant); end
        en1 = 0; step();
        total++; if ({we_a, mem_w_address, mem_w_data} !== {1'b1, a.a, a.d}) begin
            bad++; $display("FAIL to_write_a: got we=%b %h/%h want 1 %h/%h", we_a, mem_w_address, mem_w_data, a.a, a.d); end
        step(); step();
        en1 = 1; step();
        total++; if ({grant, r1_ready} !== 3'b101) begin bad++; $display("FAIL to_3idle_hold: got=%b want=101", {grant, r1_ready}); end
        en1 = 0; step();
        total++; if ({we_a, mem_w_address, mem_w_data} !== {1'b1, b.a, b.d}) begin
            bad++; $display("FAIL to_write_b: got we=%b %h/%h want 1 %h/%h", we_a, mem_w_address, mem_w_data, b.a, b.d); end
        extra_we = 0;
        for (int i = 0; i < 3; i++) begin step(); if (we_a) extra_we++; end
        total++; if ({grant, r1_ready} !== 3'b101) begin bad++; $display("FAIL to_before_4th: got=%b want=101", {grant, r1_ready}); end
        step(); if (we_a) extra_we++;
        total++; if ({grant, r1_ready} !== 3'b000) begin bad++; $display("FAIL to_release: got=%b want=000", {grant, r1_ready}); end
        total++; if (extra_we != 0) begin bad++; $display("FAIL to_spurious_we: got=%0d want=0", extra_we); end
        model_ls = 1'b1;
    endtask

    task automatic test_random_traffic();
        bit ok;
        for (int it = 0; it < 4; it++) begin
            obs.delete(); obs_g.delete(); rr_viol = 0;
            gen_bursts(0, $urandom_range(4, 0), 1, 5);
            gen_bursts(1, $urandom_range(4, 1), 1, 5);
            en0 = 1; en1 = 1;
            predict();
            run_traffic(300, ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd%0d_drain: got=stuck want=drained", it); end
            total++; if (obs != exp_wr) begin bad++; $display("FAIL rnd%0d_writes: got %0d writes want %0d (content differs)", it, obs.size(), exp_wr.size()); end
            total++; if (obs_g != exp_g || rr_viol != 0) begin bad++; $display("FAIL rnd%0d_grants: got=%p viol=%0d want=%p viol=0", it, obs_g, rr_viol, exp_g); end
        end
    endtask

    task automatic test_clear();
        beat_t saved[$];
        wr_t w;
        int nclr, addr_err, gap, busy_err, extra, burst_bad;
        bit done, ok;
        apply_reset();
        gen_bursts(0, 1, 4, 4);
        saved = q0;
        en0 = 1; drive_inputs();
        step();
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL clr_burst_grant: got=%b want=01", grant); end
        clr_req = 1'b1; clr_data = 24'h000000;
        step();
        clr_req = 1'b0;
        total++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_busy_set: got=%b want=1", clr_busy); end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (grant == 2'b00) begin ok = 1; break; end
            step();
        end
        total++; if (!ok || obs.size() != 4) begin bad++; $display("FAIL clr_burst_done: got ok=%0d writes=%0d want ok=1 writes=4", ok, obs.size()); end
        burst_bad = 0;
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            w.a = saved[i].a; w.d = saved[i].d;
            if (obs[i] !== w) burst_bad++;
        end
        total++; if (burst_bad != 0) begin bad++; $display("FAIL clr_burst_data: got %0d bad beats want 0", burst_bad); end
        nclr = 0; addr_err = 0; gap = 0; busy_err = 0; done = 0;
        for (int i = 0; i < 2100 && !done; i++) begin
            step();
            if (we_a) begin
                if (mem_w_address !== AW'(nclr) || mem_w_data !== 24'h0) addr_err++;
                nclr++;
                if (nclr == 1) clr_data = DW'($urandom) | 24'h1;
            end else if (nclr >= 2048) done = 1;
            else if (nclr > 0) gap++;
            if (!done && clr_busy !== 1'b1) busy_err++;
            clr_req = (nclr == 1000);
        end
        clr_req = 1'b0;
        total++; if (!done || nclr != 2048) begin bad++; $display("FAIL clr_count: got done=%0d writes=%0d want done=1 writes=2048", done, nclr); end
        total++; if (addr_err != 0) begin bad++; $display("FAIL clr_addr_data: got %0d bad writes want 0", addr_err); end
        total++; if (gap != 0) begin bad++; $display("FAIL clr_gap: got %0d idle cycles mid-sweep want 0", gap); end
        total++; if (busy_err != 0) begin bad++; $display("FAIL clr_busy_hold: got %0d low cycles want 0", busy_err); end
        total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_drop: got=%b want=0", clr_busy); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin step(); if (we_a || clr_busy) extra++; end
        total++; if (extra != 0) begin bad++; $display("FAIL clr_restart: got %0d active cycles after sweep want 0", extra); end
    endtask

    task automatic test_reset_mid_clear();
        bit found, ok;
        int stray;
        apply_reset();
        clr_data = 24'h5A5A5A; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (we_a && mem_w_address == 11'd100) begin found = 1; break; end
        end
        total++; if (!found) begin bad++; $display("FAIL rmc_reach100: got=not reached want=reached"); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({we_a, grant, r0_ready, r1_ready, clr_busy, mem_w_address, mem_w_data} !== '0) begin
            bad++; $display("FAIL rmc_async_zero: got we=%b g=%b busy=%b addr=%h data=%h want all 0", we_a, grant, clr_busy, mem_w_address, mem_w_data); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        obs.delete(); obs_g.delete(); rr_viol = 0; prev_grant = 2'b00; model_ls = 1'b1;
        repeat (3) step();
        total++; if (obs.size() != 0 || clr_busy !== 1'b0) begin bad++; $display("FAIL rmc_abandoned: got writes=%0d busy=%b want 0/0", obs.size(), clr_busy); end
        gen_bursts(0, 1, 1, 1); gen_bursts(1, 1, 1, 1);
        en0 = 1; en1 = 1;
        predict();
        run_traffic(50, ok);
        stray = 0;
        foreach (obs[i]) if (obs[i].a == 11'd101 && obs[i].d == 24'h5A5A5A) stray++;
        total++; if (stray != 0) begin bad++; $display("FAIL rmc_no_101: got %0d clear writes want 0", stray); end
        total++; if (!ok || obs != exp_wr) begin bad++; $display("FAIL rmc_traffic: got %0d writes want %0d", obs.size(), exp_wr.size()); end
        total++; if (obs_g.size() == 0 || obs_g[0] !== 2'b01) begin bad++; $display("FAIL rmc_first_tie: got=%p want first 01", obs_g); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_round_robin();
        test_max_burst();
        test_timeout();
        test_random_traffic();
        test_clear();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
